// File: rtl/accel_mmio_bridge.sv
// Memory-mapped bridge between the SoC memory port and one accelerator core:
// byte-maskable config registers, a control/status register and SRAM windows.
module accel_mmio_bridge #(
  parameter int          DATA_W    = 64,
  parameter int          ADDR_W    = 64,
  parameter logic [63:0] BASE_ADDR = 64'h6000_0000,
  parameter int          N_CSR     = 2,
  parameter int          N_SRAM    = 2,
  parameter int          SRAM_AW   = 10,
  parameter int          DONE_W    = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     mem_req_i,
  output logic                     mem_gnt_o,
  input  logic                     mem_we_i,
  input  logic [DATA_W/8-1:0]      mem_be_i,
  input  logic [ADDR_W-1:0]        mem_addr_i,
  input  logic [DATA_W-1:0]        mem_wdata_i,
  output logic                     mem_rvalid_o,
  output logic [DATA_W-1:0]        mem_rdata_o,
  output logic                     mem_err_o,
  output logic [N_CSR*DATA_W-1:0]  csr_cfg_o,
  output logic                     core_start_o,
  output logic [1:0]               core_mode_o,
  input  logic                     core_busy_i,
  input  logic [DONE_W-1:0]        core_done_i,
  output logic                     irq_o,
  output logic [N_SRAM-1:0]        sram_req_o,
  output logic                     sram_we_o,
  output logic [DATA_W/8-1:0]      sram_be_o,
  output logic [SRAM_AW-1:0]       sram_addr_o,
  output logic [DATA_W-1:0]        sram_wdata_o,
  input  logic [N_SRAM*DATA_W-1:0] sram_rdata_i
);

  localparam int NB = DATA_W / 8;
  localparam int BW = $clog2(NB);
  localparam logic [ADDR_W-1:0] WIN_BYTES = ADDR_W'((64'd1 << SRAM_AW) * 64'(NB));
  localparam logic [ADDR_W-1:0] CTRL_OFF  = ADDR_W'(32'h000F_0000);

  function automatic logic [DATA_W-1:0] err_pattern();
    logic [31:0]       word;
    logic [DATA_W-1:0] p;
    word = 32'hDEAD_BEEF;
    p    = '0;
    for (int i = 0; i < DATA_W; i++) p[i] = word[i % 32];
    return p;
  endfunction

  localparam logic [DATA_W-1:0] ERR_DATA = err_pattern();

  logic                acc;
  logic [ADDR_W-1:0]   offset;
  logic [ADDR_W-1:0]   aligned;
  logic [N_CSR-1:0]    cfg_hit;
  logic [N_SRAM-1:0]   sram_hit;
  logic                ctrl_hit;
  logic                mapped;

  logic [DATA_W-1:0]   cfg_q [N_CSR];
  logic [DONE_W-1:0]   done_q, done_d;
  logic                irq_en_q, irq_en_d;
  logic [1:0]          mode_q, mode_d;
  logic [1:0]          core_mode_q;
  logic                start_q;
  logic                irq_q;

  logic                ctrl_wr, ctrl_rd, start_req, start_ok, done_clr;
  logic [DATA_W-1:0]   status;
  logic [DATA_W-1:0]   rsp_data_d;
  logic [DATA_W-1:0]   sram_rd;

  logic                rsp_valid_q;
  logic                rsp_err_q;
  logic [DATA_W-1:0]   rsp_data_q;
  logic [N_SRAM-1:0]   rsp_sram_q;

  assign acc     = mem_req_i & ~rst_i;
  assign offset  = mem_addr_i - ADDR_W'(BASE_ADDR);
  assign aligned = offset & ~ADDR_W'(NB - 1);

  // Address decode; offsets below the base wrap to huge values and fall through as unmapped.
  always_comb begin
    cfg_hit  = '0;
    sram_hit = '0;
    for (int i = 0; i < N_CSR; i++)
      cfg_hit[i] = (aligned == ADDR_W'(i * 32'h0001_0000));
    for (int k = 0; k < N_SRAM; k++)
      sram_hit[k] = (offset[ADDR_W-1:20] == (ADDR_W-20)'(k + 1)) &&
                    (ADDR_W'(offset[19:0]) < WIN_BYTES);
  end

  assign ctrl_hit = (aligned == CTRL_OFF);
  assign mapped   = (|cfg_hit) | ctrl_hit | (|sram_hit);

  always_comb begin
    ctrl_wr   = acc & ctrl_hit & mem_we_i;
    ctrl_rd   = acc & ctrl_hit & ~mem_we_i;
    start_req = ctrl_wr & mem_be_i[0] & mem_wdata_i[0];
    start_ok  = start_req & ~core_busy_i & (done_q == '0);
    done_clr  = ctrl_rd | (ctrl_wr & mem_be_i[1] & mem_wdata_i[8]);
    mode_d    = mode_q;
    irq_en_d  = irq_en_q;
    if (ctrl_wr && mem_be_i[1]) begin
      mode_d   = mem_wdata_i[11:10];
      irq_en_d = mem_wdata_i[9];
    end
    // A new completion code outranks a clear arriving in the same cycle.
    done_d = done_q;
    if (core_done_i != '0) done_d = core_done_i;
    else if (done_clr)     done_d = '0;
  end

  always_comb begin
    status              = '0;
    status[DONE_W-1:0]  = done_q;
    status[8]           = core_busy_i;
    status[9]           = irq_en_q;
    status[11:10]       = mode_q;
  end

  always_comb begin
    rsp_data_d = '0;
    if (acc && !mapped) begin
      rsp_data_d = ERR_DATA;
    end else if (acc && !mem_we_i) begin
      if (ctrl_hit) rsp_data_d = status;
      for (int i = 0; i < N_CSR; i++)
        if (cfg_hit[i]) rsp_data_d = cfg_q[i];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < N_CSR; i++) cfg_q[i] <= '0;
      done_q      <= '0;
      irq_en_q    <= 1'b0;
      mode_q      <= 2'b00;
      core_mode_q <= 2'b00;
      start_q     <= 1'b0;
      irq_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= '0;
      rsp_sram_q  <= '0;
    end else begin
      for (int i = 0; i < N_CSR; i++)
        if (acc && mem_we_i && cfg_hit[i])
          for (int b = 0; b < NB; b++)
            if (mem_be_i[b]) cfg_q[i][b*8 +: 8] <= mem_wdata_i[b*8 +: 8];
      done_q      <= done_d;
      irq_en_q    <= irq_en_d;
      mode_q      <= mode_d;
      start_q     <= start_ok;
      if (start_ok) core_mode_q <= mode_d;
      irq_q       <= irq_en_d & (done_d != '0);
      rsp_valid_q <= acc;
      rsp_err_q   <= acc & (~mapped | (start_req & ~start_ok));
      rsp_data_q  <= rsp_data_d;
      rsp_sram_q  <= (acc && !mem_we_i) ? sram_hit : '0;
    end
  end

  always_comb begin
    sram_rd = '0;
    for (int k = 0; k < N_SRAM; k++)
      if (rsp_sram_q[k]) sram_rd = sram_rd | sram_rdata_i[k*DATA_W +: DATA_W];
  end

  always_comb begin
    csr_cfg_o = '0;
    if (!rst_i)
      for (int i = 0; i < N_CSR; i++) csr_cfg_o[i*DATA_W +: DATA_W] = cfg_q[i];
  end

  // Every output is forced low while reset is held, including a response already in flight.
  assign mem_gnt_o    = acc;
  assign mem_rvalid_o = rsp_valid_q & ~rst_i;
  assign mem_err_o    = rsp_err_q & ~rst_i;
  assign mem_rdata_o  = (rst_i || !rsp_valid_q) ? '0 :
                        ((|rsp_sram_q) ? sram_rd : rsp_data_q);
  assign core_start_o = start_q & ~rst_i;
  assign core_mode_o  = rst_i ? 2'b00 : core_mode_q;
  assign irq_o        = irq_q & ~rst_i;
  assign sram_req_o   = acc ? sram_hit : '0;
  assign sram_we_o    = mem_we_i & ~rst_i;
  assign sram_be_o    = rst_i ? '0 : mem_be_i;
  assign sram_addr_o  = rst_i ? '0 : offset[BW +: SRAM_AW];
  assign sram_wdata_o = rst_i ? '0 : mem_wdata_i;

endmodule

// File: tb/tb_accel_mmio_bridge.sv
// Bench for accel_mmio_bridge: directed scenarios then random traffic, all checked
// against an address-map level reference model and a behavioural SRAM per window.
module tb_accel_mmio_bridge;

  localparam int          DATA_W  = 64;
  localparam int          ADDR_W  = 64;
  localparam int          N_CSR   = 2;
  localparam int          N_SRAM  = 2;
  localparam int          SRAM_AW = 10;
  localparam int          DONE_W  = 2;
  localparam int          WORDS   = 1 << SRAM_AW;
  localparam logic [63:0] BASE    = 64'h6000_0000;

  typedef enum int {K_CFG, K_CTRL, K_SRAM, K_UNMAPPED} kind_e;

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      mem_req, mem_gnt, mem_we;
  logic [7:0]                mem_be;
  logic [63:0]               mem_addr, mem_wdata;
  logic                      mem_rvalid, mem_err;
  logic [63:0]               mem_rdata;
  logic [N_CSR*DATA_W-1:0]   csr_cfg;
  logic                      core_start;
  logic [1:0]                core_mode;
  logic                      core_busy;
  logic [DONE_W-1:0]         core_done;
  logic                      irq;
  logic [N_SRAM-1:0]         sram_req;
  logic                      sram_we;
  logic [7:0]                sram_be;
  logic [SRAM_AW-1:0]        sram_addr;
  logic [63:0]               sram_wdata;
  logic [N_SRAM*DATA_W-1:0]  sram_rdata;

  int checks = 0;
  int errors = 0;

  logic [63:0] ref_cfg  [N_CSR];
  logic [63:0] ref_sram [N_SRAM][WORDS];
  logic [1:0]  ref_done;
  logic        ref_irq_en;
  logic [1:0]  ref_mode;
  logic [1:0]  ref_core_mode;

  logic [63:0] sram_mem [N_SRAM][WORDS];
  bit          sram_loaded = 1'b0;

  always #5 clk = ~clk;

  accel_mmio_bridge #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .BASE_ADDR(BASE), .N_CSR(N_CSR),
    .N_SRAM(N_SRAM), .SRAM_AW(SRAM_AW), .DONE_W(DONE_W)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .mem_req_i(mem_req), .mem_gnt_o(mem_gnt), .mem_we_i(mem_we), .mem_be_i(mem_be),
    .mem_addr_i(mem_addr), .mem_wdata_i(mem_wdata), .mem_rvalid_o(mem_rvalid),
    .mem_rdata_o(mem_rdata), .mem_err_o(mem_err), .csr_cfg_o(csr_cfg),
    .core_start_o(core_start), .core_mode_o(core_mode), .core_busy_i(core_busy),
    .core_done_i(core_done), .irq_o(irq), .sram_req_o(sram_req), .sram_we_o(sram_we),
    .sram_be_o(sram_be), .sram_addr_o(sram_addr), .sram_wdata_o(sram_wdata),
    .sram_rdata_i(sram_rdata)
  );

  function automatic logic [63:0] sramInit(int k, int w);
    return {32'(k) + 32'hA5A5_0000, 32'(w) ^ 32'h5A5A_1234};
  endfunction

  // Behavioural SRAM per window: write merges bytes, read data appears the cycle after req.
  always @(posedge clk) begin
    if (!sram_loaded) begin
      for (int k = 0; k < N_SRAM; k++)
        for (int w = 0; w < WORDS; w++) sram_mem[k][w] <= sramInit(k, w);
      sram_rdata  <= '0;
      sram_loaded <= 1'b1;
    end else begin
      for (int k = 0; k < N_SRAM; k++)
        if (sram_req[k]) begin
          if (sram_we)
            for (int b = 0; b < 8; b++)
              if (sram_be[b]) sram_mem[k][sram_addr][b*8 +: 8] <= sram_wdata[b*8 +: 8];
          sram_rdata[k*DATA_W +: DATA_W] <= sram_mem[k][sram_addr];
        end
    end
  end

  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%h expected=%h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic decode(input logic [63:0] addr, output kind_e kind, output int idx,
                        output int word);
    logic [63:0] off;
    off  = addr - BASE;
    kind = K_UNMAPPED;
    idx  = 0;
    word = 0;
    if (off < N_CSR * 64'h1_0000 && off % 64'h1_0000 < 64'd8) begin
      kind = K_CFG;
      idx  = int'(off / 64'h1_0000);
    end else if (off >= 64'hF_0000 && off < 64'hF_0008) begin
      kind = K_CTRL;
    end else if (off >= 64'h10_0000 && off < (N_SRAM + 1) * 64'h10_0000 &&
                 off % 64'h10_0000 < WORDS * 8) begin
      kind = K_SRAM;
      idx  = int'(off / 64'h10_0000) - 1;
      word = int'((off % 64'h10_0000) / 8);
    end
  endtask

  task automatic resetModel();
    for (int i = 0; i < N_CSR; i++) ref_cfg[i] = '0;
    ref_done      = '0;
    ref_irq_en    = 1'b0;
    ref_mode      = '0;
    ref_core_mode = '0;
  endtask

  task automatic driveIdle();
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_be    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    core_busy = 1'b0;
    core_done = '0;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_gnt"}, mem_gnt, 0);
    checkOutput({tag, "_rvalid"}, mem_rvalid, 0);
    checkOutput({tag, "_err"}, mem_err, 0);
    checkOutput({tag, "_rdata"}, mem_rdata, 0);
    checkOutput({tag, "_cfg"}, csr_cfg, 0);
    checkOutput({tag, "_ctl"}, {core_start, core_mode, irq}, 0);
    checkOutput({tag, "_sram"}, {sram_req, sram_we, sram_be, sram_addr, sram_wdata}, 0);
  endtask

  // One bus cycle: drive, check the accept-cycle outputs, step the model, check the response.
  task automatic applyStimulus(input logic req, input logic we, input logic [7:0] be,
                               input logic [63:0] addr, input logic [63:0] wdata,
                               input logic busy, input logic [1:0] done);
    kind_e       kind;
    int          idx, word;
    logic        exp_err;
    logic [63:0] exp_data;
    logic [1:0]  exp_req;
    bit          exp_start, clr, chk_data;
    @(negedge clk);
    mem_req   = req;
    mem_we    = we;
    mem_be    = be;
    mem_addr  = addr;
    mem_wdata = wdata;
    core_busy = busy;
    core_done = done;
    #1;
    decode(addr, kind, idx, word);
    exp_req = (req && kind == K_SRAM) ? 2'(1 << idx) : 2'b00;
    checkOutput("gnt", mem_gnt, req);
    checkOutput("sram_req", sram_req, exp_req);
    if (exp_req != 0) begin
      checkOutput("sram_addr", sram_addr, word);
      checkOutput("sram_we", sram_we, we);
    end
    exp_err   = 1'b0;
    exp_data  = '0;
    exp_start = 1'b0;
    clr       = 1'b0;
    chk_data  = 1'b1;
    if (req) begin
      case (kind)
        K_CFG:
          if (we) begin
            for (int b = 0; b < 8; b++)
              if (be[b]) ref_cfg[idx][b*8 +: 8] = wdata[b*8 +: 8];
          end else exp_data = ref_cfg[idx];
        K_CTRL:
          if (we) begin
            if (be[0] && wdata[0]) begin
              if (busy || ref_done != 0) exp_err = 1'b1;
              else exp_start = 1'b1;
            end
            if (be[1]) begin
              ref_mode   = wdata[11:10];
              ref_irq_en = wdata[9];
              clr        = wdata[8];
            end
          end else begin
            exp_data = 64'(ref_done) | (64'(busy) << 8) | (64'(ref_irq_en) << 9) |
                       (64'(ref_mode) << 10);
            clr = 1'b1;
          end
        K_SRAM:
          if (we) begin
            for (int b = 0; b < 8; b++)
              if (be[b]) ref_sram[idx][word][b*8 +: 8] = wdata[b*8 +: 8];
          end else exp_data = ref_sram[idx][word];
        default: begin
          exp_err  = 1'b1;
          exp_data = 64'hDEADBEEF_DEADBEEF;
          chk_data = !we;
        end
      endcase
    end
    if (done != 0) ref_done = done;
    else if (clr)  ref_done = '0;
    if (exp_start) ref_core_mode = ref_mode;
    @(posedge clk);
    #1;
    checkOutput("rvalid", mem_rvalid, req);
    if (req) begin
      checkOutput("err", mem_err, exp_err);
      if (chk_data) checkOutput("rdata", mem_rdata, exp_data);
    end
    checkOutput("start", core_start, exp_start);
    checkOutput("mode", core_mode, ref_core_mode);
    checkOutput("irq", irq, ref_irq_en && ref_done != 0);
    checkOutput("cfg", csr_cfg, {ref_cfg[1], ref_cfg[0]});
  endtask

  function automatic logic [63:0] randAddr();
    int          sel;
    logic [63:0] low;
    sel = $urandom_range(0, 7);
    low = 64'($urandom_range(0, 7));
    case (sel)
      0, 1: return BASE + 64'($urandom_range(0, N_CSR - 1)) * 64'h1_0000 + low;
      2:    return BASE + 64'hF_0000 + low;
      3, 4: return BASE + 64'($urandom_range(1, N_SRAM)) * 64'h10_0000 +
                   64'($urandom_range(0, 15)) * 8 + low;
      5:    return BASE + 64'h10_2000 + 64'($urandom_range(0, 255)) * 8;
      6:    return BASE + 64'h30_0000 + low;
      default: return BASE - 64'd8;
    endcase
  endfunction

  initial begin
    logic [63:0] a, d;
    logic        w;
    resetModel();
    for (int k = 0; k < N_SRAM; k++)
      for (int i = 0; i < WORDS; i++) ref_sram[k][i] = sramInit(k, i);
    driveIdle();
    rst = 1'b1;
    // Reset held with a live SRAM request on the bus: everything must stay low.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      mem_req  = 1'b1;
      mem_addr = BASE + 64'h10_0028;
      #1;
      checkAllZero("reset");
    end
    @(negedge clk);
    rst = 1'b0;
    driveIdle();

    applyStimulus(1, 1, 8'hFF, BASE, 64'h1122_3344_5566_7788, 0, 0);
    applyStimulus(1, 1, 8'h01, BASE, 64'hFF, 0, 0);
    applyStimulus(1, 0, 8'hFF, BASE, 0, 0, 0);
    checkOutput("cfg_merge", mem_rdata, 64'h1122_3344_5566_77FF);

    applyStimulus(1, 1, 8'hFF, 64'h6020_0028, 64'hA5, 0, 0);
    applyStimulus(1, 0, 8'hFF, 64'h6020_0028, 0, 0, 0);
    checkOutput("sram1_rd", mem_rdata, 64'hA5);
    applyStimulus(1, 0, 8'hFF, 64'h6010_0028, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);

    applyStimulus(1, 1, 8'h03, BASE + 64'hF_0000, 64'h0601, 0, 0);
    checkOutput("start_mode", {core_start, core_mode}, 3'b101);
    applyStimulus(0, 0, 0, 0, 0, 1, 2'b01);
    checkOutput("irq_set", irq, 1);
    applyStimulus(1, 0, 8'hFF, BASE + 64'hF_0000, 0, 0, 0);
    checkOutput("ctrl_rd", mem_rdata, 64'h601);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);

    applyStimulus(1, 1, 8'h03, BASE + 64'hF_0000, 64'h0601, 1, 0);
    checkOutput("busy_reject", {mem_err, core_start}, 2'b10);
    applyStimulus(0, 0, 0, 0, 0, 0, 2'b10);
    applyStimulus(1, 1, 8'h01, BASE + 64'hF_0000, 64'h0001, 0, 0);
    checkOutput("done_reject", {mem_err, core_start}, 2'b10);
    applyStimulus(1, 0, 8'hFF, BASE + 64'hF_0000, 0, 0, 0);

    applyStimulus(1, 1, 8'h02, BASE + 64'hF_0000, 64'h0100, 0, 2'b11);
    applyStimulus(1, 0, 8'hFF, BASE + 64'hF_0000, 0, 0, 0);
    checkOutput("capture_wins", mem_rdata[1:0], 2'b11);

    applyStimulus(1, 0, 8'hFF, 64'h6000_5000, 0, 0, 0);
    applyStimulus(1, 0, 8'hFF, 64'h6030_0000, 0, 0, 0);
    checkOutput("unmapped", {mem_err, mem_rdata}, {1'b1, 64'hDEADBEEF_DEADBEEF});

    // Read accepted in the cycle just before reset must never respond.
    @(negedge clk);
    mem_req  = 1'b1;
    mem_we   = 1'b0;
    mem_be   = 8'hFF;
    mem_addr = BASE;
    @(negedge clk);
    driveIdle();
    rst = 1'b1;
    #1;
    checkAllZero("late_reset");
    @(negedge clk);
    rst = 1'b0;
    resetModel();
    applyStimulus(0, 0, 0, 0, 0, 0, 0);

    for (int n = 0; n < 400; n++) begin
      a = randAddr();
      w = 1'($urandom_range(0, 1));
      d = {$urandom, $urandom};
      applyStimulus(1'($urandom_range(0, 4) != 0), w, 8'($urandom), a, d,
                    1'($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/accel_mmio_bridge.md
Name: accel_mmio_bridge

Overview:
- Parametrised memory-mapped bridge between the SoC's single-outstanding-per-cycle memory port and one accelerator core.
- Provides the following to the core:
  - N_CSR byte-maskable configuration registers.
  - A control/status register with start pulse, sticky done flags and an interrupt.
  - N_SRAM independent SRAM windows.
- Every accepted access gets exactly one response one cycle later, including an error flag for unmapped addresses.

Parameters:
DATA_W, 64, bus/SRAM data width (multiple of 8)
ADDR_W, 64, bus address width
BASE_ADDR, 64'h6000_0000, base of the block's address space
N_CSR, 2, number of config registers (1..15)
N_SRAM, 2, number of SRAM windows (1..7)
SRAM_AW, 10, SRAM word-address width; window size = 2^SRAM_AW * DATA_W/8 bytes
DONE_W, 2, width of core done code

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
mem_req_i  in  1  access request
mem_gnt_o  out  1  request accepted this cycle
mem_we_i  in  1  1 = write
mem_be_i  in  DATA_W/8  byte enables
mem_addr_i  in  ADDR_W  byte address
mem_wdata_i  in  DATA_W  write data
mem_rvalid_o  out  1  response valid (reads and writes)
mem_rdata_o  out  DATA_W  read data
mem_err_o  out  1  response is an error
csr_cfg_o  out  N_CSR*DATA_W  config registers, CSR i at [i*DATA_W +: DATA_W]
core_start_o  out  1  one-cycle start pulse
core_mode_o  out  2  operation mode latched at start
core_busy_i  in  1  core busy
core_done_i  in  DONE_W  nonzero for one cycle = operation finished with that code
irq_o  out  1  interrupt
sram_req_o  out  N_SRAM  per-window request
sram_we_o  out  1  shared write enable
sram_be_o  out  DATA_W/8  shared byte enables
sram_addr_o  out  SRAM_AW  shared word address
sram_wdata_o  out  DATA_W  shared write data
sram_rdata_i  in  N_SRAM*DATA_W  per-window read data, valid one cycle after req

Behaviour:

Reset:
- All outputs 0.
- CSRs, status, mode and response pipeline cleared.
- A request accepted in the cycle before reset produces no response.

Address map (offset = mem_addr_i - BASE_ADDR):
- CFG i: offset i*0x1_0000, i < N_CSR.
- CTRL: offset 0xF_0000.
- SRAM k: offset (k+1)*0x10_0000 + byte offset, where byte offset < window size.
- Word address = byte offset >> log2(DATA_W/8).
- Low address bits inside a word are ignored.
- Everything else is unmapped.

Handshake:
- mem_gnt_o = mem_req_i whenever not in reset; there are no stalls.
- Back-to-back requests are accepted every cycle.
- Each accepted request yields mem_rvalid_o exactly 1 cycle later.
- mem_rdata_o is valid only with rvalid; it is 0 for writes.

CFG write:
- Byte-merge: only bytes with mem_be_i set update; other bytes hold.
- Read returns the full register.

CTRL read layout:
- [DONE_W-1:0] sticky done code.
- [8] busy (core_busy_i sampled at access).
- [9] irq_en.
- [11:10] mode.
- All other bits 0.

CTRL write (byte 0 and byte 1 enables are honoured):
- bit 0 = start.
- bits [11:10] = mode.
- bit 9 = irq_en.
- bit 8 = write-1-to-clear done.

Start:
- A CTRL write with start=1 while core_busy_i=0 and sticky done = 0 pulses core_start_o the next cycle and latches core_mode_o.
- If core_busy_i=1 or done is still pending, the start is dropped and the response has mem_err_o=1.

Done capture:
- core_done_i != 0 loads the sticky done register.
- A CTRL read clears sticky done after returning it.
- A W1C via bit 8 also clears it.
- If a capture and a clear occur in the same cycle, the capture wins.

Interrupt:
- irq_o registered: irq_o = irq_en & (sticky done != 0).

SRAM access:
- The addressed window's sram_req_o bit is asserted combinationally in the accept cycle; all other signals are driven from the bus.
- Non-selected windows see req = 0.
- Selected window index is registered for one cycle.
- mem_rdata_o = that window's sram_rdata_i in the response cycle.

Unmapped access:
- No side effects.
- Response mem_err_o=1, rdata = DEADBEEF pattern repeated/truncated to DATA_W.

Fixed latency:
- CSR read data is registered so CSR and SRAM reads both return 1 cycle after accept.

Test Plan:
1. Reset, then write CFG0 = 64'h1122_3344_5566_7788 with be=8'hFF; write be=8'h01 data 64'hFF -> read CFG0 returns 64'h1122_3344_5566_77FF, rvalid 1 cycle after each gnt, err=0.
2. Write 64'hA5 to SRAM1 word 5 (addr 0x6020_0028), then read it back-to-back with a read of SRAM0 word 5 -> responses on consecutive cycles: 64'hA5, then SRAM0 contents; sram_req_o = 2'b10 then 2'b01.
3. CTRL write 0x0601 (start, mode=1, irq_en=1) with busy=0 -> core_start_o high exactly 1 cycle, core_mode_o=1. Pulse core_done_i=2'b01 -> irq_o=1 next cycle. CTRL read returns 0x601 | 0x200 pattern with done=01, then irq_o=0 and done=0.
4. Start while core_busy_i=1 -> no start pulse, mem_err_o=1. Start with done pending -> same result.
5. core_done_i=2'b11 in the same cycle as a CTRL W1C write -> sticky done = 11 afterwards.
6. Read 0x6000_5000 and 0x6030_0000 (when N_SRAM=2) -> err=1, rdata = 64'hDEADBEEF_DEADBEEF. Assert rst_i the cycle after an accepted read -> no rvalid, all outputs 0.
